// File: rtl/axis_uart_pkg.sv
// Shared constants, FSM state type and parity helper for the axis_uart receive path.
package axis_uart_pkg;

   // Parity modes
   localparam int unsigned PAR_NONE  = 0;
   localparam int unsigned PAR_EVEN  = 1;
   localparam int unsigned PAR_ODD   = 2;
   localparam int unsigned PAR_MARK  = 3;
   localparam int unsigned PAR_SPACE = 4;

   // m_axis_tuser bit positions
   localparam int unsigned TUSER_PERR = 0;
   localparam int unsigned TUSER_FERR = 1;
   localparam int unsigned TUSER_BRK  = 2;

   localparam int unsigned MIN_PRESCALER = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBrkWait,
      StAbWait,
      StAbMeas
   } state_e;

   // Parity bit the transmitter should have sent for the given mode
   function automatic logic parity_bit(input int unsigned mode, input logic data_xor);
      case (mode)
         PAR_EVEN: parity_bit = data_xor;
         PAR_ODD:  parity_bit = !data_xor;
         PAR_MARK: parity_bit = 1'b1;
         default:  parity_bit = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/axis_uart_fifo.sv
// Synchronous first-word-fall-through FIFO with exact full/empty and an AXIS-style read side.
module axis_uart_fifo #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_valid,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_rd_data,
   input  logic             i_rd_ready
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_rd;
   logic             w_wr;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_empty   = (r_wptr == r_rptr);
   assign w_rd      = !o_empty && i_rd_ready;
   // A read in the same cycle frees a slot, so a write while full is still accepted
   assign w_wr      = i_wr_valid && (!o_full || w_rd);
   assign o_rd_data = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

   // Pointer update
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   // Storage; contents are don't-care until the write pointer covers them
   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
   end

endmodule

// File: rtl/axis_uart_rx_ab.sv
// UART receiver with 0x55 auto-baud measurement, break handling and AXI-Stream output via FIFO.
// Optional feature macro: AXIS_UART_RX_BREAK_EN (flag line breaks in tuser[2] with tdata=0).
module axis_uart_rx_ab
   import axis_uart_pkg::*;
#(
   parameter int unsigned PRESCALER_WIDTH   = 16,
   parameter int unsigned DEFAULT_PRESCALER = 1085,
   parameter int unsigned BYTE_SIZE         = 8,
   parameter int unsigned PARITY            = 0,
   parameter int unsigned STOP_BITS         = 0,
   parameter int unsigned FIFO_DEPTH        = 32
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       rx,
   input  logic [PRESCALER_WIDTH-1:0] s_axis_config_tdata,
   input  logic                       s_axis_config_tvalid,
   output logic                       s_axis_config_tready,
   input  logic                       ab_req,
   output logic                       ab_done,
   output logic                       ab_err,
   output logic [PRESCALER_WIDTH-1:0] prescaler,
   output logic [15:0]                m_axis_tdata,
   output logic [2:0]                 m_axis_tuser,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       overrun
);
   localparam int unsigned PW = PRESCALER_WIDTH;
   localparam int unsigned MW = PRESCALER_WIDTH + 3;
   localparam int unsigned FW = BYTE_SIZE + 3;

   state_e         r_state, w_state_next;
   logic           r_rx_meta, r_rx_sync, r_rx_prev;
   logic [PW-1:0]  r_prescaler, r_cnt, w_cfg_val;
   logic [MW-1:0]  r_meas;
   logic [1:0]     r_edges;
   logic [3:0]     r_bit;
   logic [15:0]    r_data;
   logic           r_stop_idx, r_stop0_zero, r_perr, r_ferr, r_par_zero;
   logic           r_ab_pend, r_ab_done, r_ab_err, r_overrun, r_wr_vld;
   logic [FW-1:0]  r_wr_data, w_fifo_data;
   logic           w_fall, w_tick, w_last_data, w_last_stop, w_stop0_zero, w_brk;
   logic           w_meas_sat, w_ab_ok, w_fifo_full, w_fifo_empty, w_fifo_rd;
   logic [MW:0]    w_ab_sum;
   logic [PW:0]    w_ab_res;
   logic [2:0]     w_frame_user;
   logic [BYTE_SIZE-1:0] w_frame_data;

   assign w_fall      = !r_rx_sync && r_rx_prev;
   assign w_tick      = (r_cnt <= PW'(1));
   assign w_last_data = (r_bit == 4'(BYTE_SIZE - 1));
   assign w_last_stop = (STOP_BITS == 0) || r_stop_idx;
   assign w_cfg_val   = (s_axis_config_tdata < PW'(MIN_PRESCALER)) ? PW'(MIN_PRESCALER)
                                                                    : s_axis_config_tdata;
   // Count at the 4th edge is r_meas+1, so (count+4)>>3 becomes (r_meas+5)>>3
   assign w_meas_sat  = &r_meas;
   assign w_ab_sum    = {1'b0, r_meas} + (MW+1)'(5);
   assign w_ab_res    = w_ab_sum[MW:3];
   assign w_ab_ok     = !w_ab_res[PW] && (w_ab_res[PW-1:0] >= PW'(MIN_PRESCALER));
   assign w_fifo_rd   = m_axis_tvalid && m_axis_tready;

   assign prescaler     = r_prescaler;
   assign ab_done       = r_ab_done;
   assign ab_err        = r_ab_err;
   assign overrun       = r_overrun;
   assign m_axis_tvalid = !w_fifo_empty;
   assign m_axis_tuser  = w_fifo_data[FW-1:BYTE_SIZE];
   assign m_axis_tdata  = 16'(w_fifo_data[BYTE_SIZE-1:0]);

   // Frame status assembled at the last stop sample
   always_comb begin
      w_stop0_zero = r_stop_idx ? r_stop0_zero : !r_rx_sync;
      w_brk        = (r_data == '0) && r_par_zero && w_stop0_zero;
      w_frame_user = '0;
      w_frame_user[TUSER_PERR] = r_perr;
      w_frame_user[TUSER_FERR] = r_ferr || !r_rx_sync;
      w_frame_data = r_data[BYTE_SIZE-1:0];
`ifdef AXIS_UART_RX_BREAK_EN
      if (w_brk) begin
         w_frame_user = '0;
         w_frame_user[TUSER_BRK] = 1'b1;
         w_frame_data = '0;
      end
`endif
   end

   // Next-state logic and config ready
   always_comb begin
      w_state_next         = r_state;
      s_axis_config_tready = 1'b0;
      unique case (r_state)
         StIdle: begin
            s_axis_config_tready = !r_ab_pend && !ab_req;
            if (r_ab_pend)   w_state_next = StAbWait;
            else if (w_fall) w_state_next = StStart;
         end
         StStart:   if (w_tick) w_state_next = r_rx_sync ? StIdle : StData;
         StData:    if (w_tick && w_last_data)
                       w_state_next = (PARITY != PAR_NONE) ? StParity : StStop;
         StParity:  if (w_tick) w_state_next = StStop;
         StStop:    if (w_tick && w_last_stop) w_state_next = w_brk ? StBrkWait : StIdle;
         StBrkWait: if (r_rx_sync) w_state_next = StIdle;
         StAbWait:  if (w_fall) w_state_next = StAbMeas;
         StAbMeas:  if (w_meas_sat || (w_fall && r_edges == 2'd3)) w_state_next = StBrkWait;
         default:   w_state_next = StIdle;
      endcase
   end

   // State register and rx synchroniser (idle-high reset avoids a false edge)
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= StIdle;
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // Datapath: bit timing, shifting, FIFO write, auto-baud measurement, config
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_prescaler  <= PW'(DEFAULT_PRESCALER);
         r_cnt        <= '0;
         r_meas       <= '0;
         r_edges      <= '0;
         r_bit        <= '0;
         r_data       <= '0;
         r_stop_idx   <= 1'b0;
         r_stop0_zero <= 1'b0;
         r_perr       <= 1'b0;
         r_ferr       <= 1'b0;
         r_par_zero   <= 1'b1;
         r_ab_pend    <= 1'b0;
         r_ab_done    <= 1'b0;
         r_ab_err     <= 1'b0;
         r_overrun    <= 1'b0;
         r_wr_vld     <= 1'b0;
         r_wr_data    <= '0;
      end else begin
         r_ab_done <= 1'b0;
         r_ab_err  <= 1'b0;
         r_wr_vld  <= 1'b0;
         r_overrun <= r_wr_vld && w_fifo_full && !w_fifo_rd;
         r_ab_pend <= ab_req || (r_ab_pend && (r_state != StIdle));
         if (!w_tick) r_cnt <= r_cnt - 1'b1;
         else if (r_state inside {StStart, StData, StParity, StStop}) r_cnt <= r_prescaler;
         case (r_state)
            StIdle: begin
               if (s_axis_config_tvalid && s_axis_config_tready) r_prescaler <= w_cfg_val;
               if (!r_ab_pend && w_fall) begin
                  r_cnt      <= r_prescaler >> 1;
                  r_data     <= '0;
                  r_bit      <= '0;
                  r_stop_idx <= 1'b0;
                  r_perr     <= 1'b0;
                  r_ferr     <= 1'b0;
                  r_par_zero <= 1'b1;
               end
            end
            StData: if (w_tick) begin
               r_data[r_bit] <= r_rx_sync;
               r_bit         <= r_bit + 1'b1;
            end
            StParity: if (w_tick) begin
               r_perr     <= (r_rx_sync != parity_bit(PARITY, ^r_data));
               r_par_zero <= !r_rx_sync;
            end
            StStop: if (w_tick) begin
               r_stop_idx   <= 1'b1;
               r_stop0_zero <= w_stop0_zero;
               r_ferr       <= r_ferr || !r_rx_sync;
               if (w_last_stop) begin
                  r_wr_vld  <= 1'b1;
                  r_wr_data <= {w_frame_user, w_frame_data};
               end
            end
            StAbWait: if (w_fall) begin
               r_meas  <= '0;
               r_edges <= '0;
            end
            StAbMeas: begin
               if (w_meas_sat) begin
                  r_ab_err <= 1'b1;
               end else begin
                  r_meas <= r_meas + 1'b1;
                  if (w_fall) begin
                     r_edges <= r_edges + 1'b1;
                     if (r_edges == 2'd3) begin
                        if (w_ab_ok) begin
                           r_prescaler <= w_ab_res[PW-1:0];
                           r_ab_done   <= 1'b1;
                        end else begin
                           r_ab_err <= 1'b1;
                        end
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   axis_uart_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (aclk),
      .i_rst_n    (aresetn),
      .i_wr_valid (r_wr_vld),
      .i_wr_data  (r_wr_data),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_rd_data  (w_fifo_data),
      .i_rd_ready (m_axis_tready)
   );

endmodule
